vreg_loader: RTL and testbench

//  Writer side of the vector register file write port (WE3/A3/WD3).

---
 rtl/vreg_pkg.sv | 20 ++
 rtl/vec_assembler.sv | 48 ++++
 rtl/vreg_loader.sv | 128 ++++++++++++
 tb/tb_vreg_loader.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vreg_pkg.sv
// Shared sizes and types for the vector-register preload path.
package vreg_pkg;

    localparam int unsigned LANES      = 6;
    localparam int unsigned LANE_W     = 8;
    localparam int unsigned NREGS      = 10;
    localparam int unsigned IDX_W      = 4;
    localparam int unsigned LANE_CNT_W = $clog2(LANES);
    localparam int unsigned SUM_W      = IDX_W + 1;

    typedef logic [LANES-1:0][LANE_W-1:0] vec_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } vload_state_t;

endpackage

// File: rtl/vec_assembler.sv
// Lane counter plus byte-insert buffer; vec_c/full_c reflect the buffer
// including the byte being pushed this cycle.
module vec_assembler
    import vreg_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              push_i,
    input  logic [LANE_W-1:0] byte_i,
    output vec_t              vec_c,
    output logic              full_c
);

    logic [LANE_CNT_W-1:0] lane_q, lane_d;
    vec_t                  lane_buf_q, lane_buf_d;

    // Insert the pushed byte at the current lane; wrap after the last lane.
    always_comb begin
        lane_d     = lane_q;
        lane_buf_d = lane_buf_q;
        full_c     = 1'b0;
        if (clr_i) begin
            lane_d     = '0;
            lane_buf_d = '0;
        end else if (push_i) begin
            lane_buf_d[lane_q] = byte_i;
            if (lane_q == LANE_CNT_W'(LANES - 1)) begin
                lane_d = '0;
                full_c = 1'b1;
            end else begin
                lane_d = lane_q + LANE_CNT_W'(1);
            end
        end
        vec_c = lane_buf_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q     <= '0;
            lane_buf_q <= '0;
        end else begin
            lane_q     <= lane_d;
            lane_buf_q <= lane_buf_d;
        end
    end

endmodule

// File: rtl/vreg_loader.sv
// Writer side of the vector regfile write port: packs a byte stream into
// vectors and writes them to consecutive registers from a base index.
module vreg_loader
    import vreg_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [IDX_W-1:0] base_idx,
    input  logic [IDX_W-1:0] count,
    input  logic             in_valid,
    input  logic [LANE_W-1:0] in_byte,
    output logic             in_ready,
    output logic             we,
    output logic [IDX_W-1:0] wa,
    output vec_t             wd,
    output logic             busy,
    output logic             done,
    output logic             err
);

    vload_state_t     state_q, state_d;
    logic [IDX_W-1:0] cur_idx_q, cur_idx_d;
    logic [IDX_W-1:0] left_q, left_d;

    logic             in_ready_q, we_q, busy_q, done_q, err_q;
    logic             err_d;
    logic [IDX_W-1:0] wa_q, wa_d;
    vec_t             wd_q, wd_d;

    logic [SUM_W-1:0] bound_sum_c;
    logic             start_bad_c;
    logic             start_ok_c;
    logic             push_c;
    vec_t             vec_c;
    logic             full_c;

    // Bounds check is one bit wider than the index so base+count cannot wrap.
    assign bound_sum_c = {1'b0, base_idx} + {1'b0, count};
    assign start_bad_c = (count == '0) || (bound_sum_c > SUM_W'(NREGS));
    assign start_ok_c  = (state_q == IDLE) && start && !start_bad_c;
    assign push_c      = in_valid && in_ready_q;

    vec_assembler u_asm (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (start_ok_c),
        .push_i (push_c),
        .byte_i (in_byte),
        .vec_c  (vec_c),
        .full_c (full_c)
    );

    always_comb begin
        state_d   = state_q;
        cur_idx_d = cur_idx_q;
        left_d    = left_q;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (start_bad_c) begin
                        err_d = 1'b1;
                    end else begin
                        state_d   = FILL;
                        cur_idx_d = base_idx;
                        left_d    = count;
                    end
                end
            end
            FILL: begin
                if (full_c) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                cur_idx_d = cur_idx_q + IDX_W'(1);
                left_d    = left_q - IDX_W'(1);
                state_d   = (left_q == IDX_W'(1)) ? DONE : FILL;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Output registers are loaded from next-state so they line up with state_q.
        wa_d = (state_d == WRITE) ? cur_idx_q : wa_q;
        wd_d = full_c ? vec_c : wd_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cur_idx_q  <= '0;
            left_q     <= '0;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            wa_q       <= '0;
            wd_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_idx_q  <= cur_idx_d;
            left_q     <= left_d;
            in_ready_q <= (state_d == FILL);
            we_q       <= (state_d == WRITE);
            wa_q       <= wa_d;
            wd_q       <= wd_d;
            busy_q     <= (state_d != IDLE);
            done_q     <= (state_d == DONE);
            err_q      <= err_d;
        end
    end

    assign in_ready = in_ready_q;
    assign we       = we_q;
    assign wa       = wa_q;
    assign wd       = wd_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_vreg_loader.sv
// Self-checking bench for vreg_loader: vector table of load requests plus
// hand-written reset and mid-load start sequences.
module tb_vreg_loader;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [3:0]      base_idx = '0;
    logic [3:0]      count = '0;
    logic            in_valid = 1'b0;
    logic [7:0]      in_byte = '0;
    logic            in_ready, we, busy, done, err;
    logic [3:0]      wa;
    logic [5:0][7:0] wd;

    always #5 clk = ~clk;

    vreg_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .base_idx (base_idx),
        .count    (count),
        .in_valid (in_valid),
        .in_byte  (in_byte),
        .in_ready (in_ready),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    int total = 0;
    int bad   = 0;

    // Cycle counter and write/pulse monitor (sampled on the falling edge).
    int          cyc = 0;
    logic [3:0]  obs_wa[$];
    logic [47:0] obs_wd[$];
    int          obs_cyc[$];
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          ir_bad = 0;
    int          ovl = 0;
    int          last_done_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (we) begin
            obs_wa.push_back(wa);
            obs_wd.push_back(wd);
            obs_cyc.push_back(cyc);
            if (in_ready) ir_bad <= ir_bad + 1;
        end
        if (done) begin
            done_cnt      <= done_cnt + 1;
            last_done_cyc <= cyc;
        end
        if (err) err_cnt <= err_cnt + 1;
        if (done && err) ovl <= ovl + 1;
    end

    logic [7:0] stream[$];

    typedef struct {
        int base;
        int cnt;
        int gap;
        bit exp_err;
    } vec_rec_t;

    vec_rec_t tbl[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic fill_random(input int n);
        stream.delete();
        for (int i = 0; i < n; i++) stream.push_back(8'($urandom));
    endtask

    function automatic logic [47:0] exp_vec(input int off);
        logic [47:0] v;
        v = '0;
        for (int l = 0; l < 6; l++) v[l*8 +: 8] = stream[off + l];
        return v;
    endfunction

    // Offer n bytes from stream[off..]; gap is the percentage of idle cycles.
    task automatic send_stream(input int off, input int n, input int gap, output int hs_cyc);
        int i;
        int guard;
        i      = 0;
        guard  = 0;
        hs_cyc = 0;
        while (i < n && guard < 2000) begin
            @(negedge clk);
            guard++;
            if (int'($urandom_range(99)) < gap) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_byte  = stream[off + i];
                if (in_ready) begin
                    i++;
                    hs_cyc = cyc + 1;
                end
            end
        end
        chk("stream_accepted", 64'(i), 64'(n));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 200);
        chk("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic check_writes(input int w0, input int base, input int cnt);
        chk("n_writes", 64'(obs_wa.size() - w0), 64'(cnt));
        for (int k = 0; k < cnt; k++) begin
            if (w0 + k < obs_wa.size()) begin
                chk("wa", 64'(obs_wa[w0 + k]), 64'(base + k));
                chk("wd", 64'(obs_wd[w0 + k]), 64'(exp_vec(6 * k)));
            end
        end
    endtask

    task automatic pulse_start(input int base, input int cnt);
        @(negedge clk);
        start    = 1'b1;
        base_idx = 4'(base);
        count    = 4'(cnt);
        @(negedge clk);
        start = 1'b0;
    endtask

    // One complete load request against the current stream contents.
    task automatic run_case(input int base, input int cnt, input int gap, input bit exp_err);
        int w0, d0, e0, hs;
        w0 = obs_wa.size();
        d0 = done_cnt;
        e0 = err_cnt;
        pulse_start(base, cnt);
        if (exp_err) begin
            chk("err_pulse", 64'(err), 64'd1);
            chk("busy_on_reject", 64'(busy), 64'd0);
            repeat (3) @(negedge clk);
            chk("busy_after_reject", 64'(busy), 64'd0);
            chk("err_count", 64'(err_cnt - e0), 64'd1);
            chk("done_on_reject", 64'(done_cnt - d0), 64'd0);
            chk("writes_on_reject", 64'(obs_wa.size() - w0), 64'd0);
        end else begin
            chk("busy_after_start", 64'(busy), 64'd1);
            send_stream(0, 6 * cnt, gap, hs);
            wait_idle();
            check_writes(w0, base, cnt);
            chk("done_count", 64'(done_cnt - d0), 64'd1);
            chk("err_on_load", 64'(err_cnt - e0), 64'd0);
            if (obs_cyc.size() >= w0 + cnt) begin
                chk("we_latency", 64'(obs_cyc[w0 + cnt - 1]), 64'(hs));
                chk("done_latency", 64'(last_done_cyc), 64'(hs + 1));
            end
        end
    endtask

    task automatic check_all_zero(input string name);
        chk(name, {47'd0, in_ready, we, busy, done, err, wa, 48'(wd)} , 64'd0);
    endtask

    initial begin
        int w0, d0, e0, hs;

        tbl[0]  = '{2, 1, 0, 1'b0};
        tbl[1]  = '{0, 3, 0, 1'b0};
        tbl[2]  = '{8, 3, 0, 1'b1};
        tbl[3]  = '{0, 0, 0, 1'b1};
        tbl[4]  = '{0, 2, 50, 1'b0};
        tbl[5]  = '{4, 6, 30, 1'b0};
        tbl[6]  = '{9, 1, 0, 1'b0};
        tbl[7]  = '{6, 4, 0, 1'b0};
        tbl[8]  = '{9, 2, 0, 1'b1};
        tbl[9]  = '{15, 1, 0, 1'b1};
        tbl[10] = '{15, 15, 0, 1'b1};
        tbl[11] = '{0, 10, 20, 1'b0};
        tbl[12] = '{10, 0, 0, 1'b1};
        tbl[13] = '{3, 7, 0, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        check_all_zero("reset_outputs");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset_outputs");

        // Single vector, fixed bytes 0x11..0x66 into register 2
        stream.delete();
        for (int i = 1; i <= 6; i++) stream.push_back(8'(i * 8'h11));
        w0 = obs_wa.size();
        run_case(2, 1, 0, 1'b0);
        if (obs_wd.size() > w0) begin
            chk("t1_wd_const", 64'(obs_wd[w0]), 64'h0000_6655_4433_2211);
            chk("t1_wa_const", 64'(obs_wa[w0]), 64'd2);
        end

        // Three vectors of an incrementing stream, then a gapped two-vector reload
        stream.delete();
        for (int i = 0; i < 18; i++) stream.push_back(8'(i));
        run_case(0, 3, 0, 1'b0);
        run_case(0, 2, 50, 1'b0);

        // Table of random loads and rejected requests
        for (int t = 0; t < 14; t++) begin
            fill_random(6 * tbl[t].cnt);
            run_case(tbl[t].base, tbl[t].cnt, tbl[t].gap, tbl[t].exp_err);
        end

        // Reset after 4 bytes of a vector: nothing written, then a fresh load
        fill_random(12);
        w0 = obs_wa.size();
        pulse_start(1, 2);
        send_stream(0, 4, 0, hs);
        rst_n = 1'b0;
        @(negedge clk);
        check_all_zero("midload_reset_outputs");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("after_midload_reset");
        chk("no_write_on_reset", 64'(obs_wa.size() - w0), 64'd0);
        fill_random(6);
        run_case(5, 1, 0, 1'b0);

        // A start pulse during a load is ignored
        fill_random(12);
        w0 = obs_wa.size();
        d0 = done_cnt;
        e0 = err_cnt;
        pulse_start(4, 2);
        send_stream(0, 3, 0, hs);
        pulse_start(0, 1);
        send_stream(3, 9, 0, hs);
        wait_idle();
        check_writes(w0, 4, 2);
        chk("midload_start_done", 64'(done_cnt - d0), 64'd1);
        chk("midload_start_err", 64'(err_cnt - e0), 64'd0);

        chk("ready_during_we", 64'(ir_bad), 64'd0);
        chk("done_err_overlap", 64'(ovl), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
